// File: rtl/control_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_sequencer : multi-cycle T-state control unit for the single-bus CPU;
// optional macro STEP_EN adds a step input and an IDLE state.   Rev 1.0
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int         MEM_LAT = 1,
  parameter logic [4:0] ADD_OP  = 5'b00011,
  parameter logic [4:0] AND_OP  = 5'b00101,
  parameter logic [4:0] OR_OP   = 5'b00110
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_output,
`ifdef STEP_EN
  input  logic        step,
`endif
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowout,
  output logic        Cout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_low_enable,
  output logic        Read,
  output logic        Write,
  output logic        CON_in,
  output logic [4:0]  operation,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef STEP_EN
    , S_IDLE
`endif
  } state_t;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

  state_t     state;
  state_t     after_done;
  logic [2:0] wait_cnt;
  logic [4:0] op;
  logic       is_r, is_imm, is_ld, is_ldi, is_st, is_br, is_jr, is_halt;
  logic       last_wait;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_r      = (op >= 5'd3) && (op <= 5'd11);
  assign is_imm    = (op >= 5'd12) && (op <= 5'd14);
  assign is_ld     = (op == 5'd0);
  assign is_ldi    = (op == 5'd1);
  assign is_st     = (op == 5'd2);
  assign is_br     = (op == 5'd18);
  assign is_jr     = (op == 5'd19);
  assign is_halt   = (op == 5'd27);
  assign last_wait = (wait_cnt == LAST_WAIT);

`ifdef STEP_EN
  assign after_done = S_IDLE;
`else
  assign after_done = S_T0;
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RST: state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          wait_cnt <= '0;
        end
        S_T1:
          if (last_wait) state <= S_T2;
          else           wait_cnt <= wait_cnt + 3'd1;
        S_T2: state <= S_T3;
        S_T3:
          if (is_r || is_imm || is_ld || is_ldi || is_st || is_br) state <= S_T4;
          else if (is_halt)                                        state <= S_HALT;
          else                                                     state <= after_done;
        S_T4: state <= S_T5;
        S_T5:
          if (is_ld || is_st || is_br) begin
            state    <= S_T6;
            wait_cnt <= '0;
          end else begin
            state <= after_done;
          end
        S_T6:
          if (is_ld) begin
            if (last_wait) state <= S_T7;
            else           wait_cnt <= wait_cnt + 3'd1;
          end else if (is_st) begin
            state <= S_T7;
          end else begin
            state <= after_done;
          end
        S_T7:   state <= after_done;
        S_HALT: state <= S_HALT;
`ifdef STEP_EN
        S_IDLE: if (step) state <= S_T0;
`endif
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; ZLowout = 1'b0; Cout = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PC_enable = 1'b0; IncPC = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0;
    IR_enable = 1'b0; Y_enable = 1'b0; Z_low_enable = 1'b0;
    Read = 1'b0; Write = 1'b0; CON_in = 1'b0;
    operation = 5'd0; instr_done = 1'b0; halted = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDR_enable = last_wait; end
      S_T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
      S_T3:
        if (is_r || is_imm) begin
          GRB = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
        end else if (is_ld || is_ldi || is_st) begin
          GRB = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
        end else if (is_br) begin
          GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1;
        end else if (is_jr) begin
          GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; instr_done = 1'b1;
        end else begin
          instr_done = 1'b1;
        end
      S_T4:
        if (is_r) begin
          GRC = 1'b1; Rout = 1'b1; operation = op; Z_low_enable = 1'b1;
        end else if (is_imm) begin
          Cout = 1'b1; Z_low_enable = 1'b1;
          operation = (op == 5'd12) ? ADD_OP : (op == 5'd13) ? AND_OP : OR_OP;
        end else if (is_ld || is_ldi || is_st) begin
          Cout = 1'b1; operation = ADD_OP; Z_low_enable = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Y_enable = 1'b1;
        end
      S_T5:
        if (is_ld || is_st) begin
          ZLowout = 1'b1; MAR_enable = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; operation = ADD_OP; Z_low_enable = 1'b1;
        end else begin
          ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end
      S_T6:
        if (is_ld) begin
          Read = 1'b1; MDR_enable = last_wait;
        end else if (is_st) begin
          GRA = 1'b1; Rout = 1'b1; MDR_enable = 1'b1;
        end else begin
          // Branch target only reaches the PC when the condition FF is set.
          instr_done = 1'b1; ZLowout = CON_output; PC_enable = CON_output;
        end
      S_T7:
        if (is_ld) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else begin
          Write = 1'b1; instr_done = 1'b1;
        end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer: directed table, corner sequences and randomized checks
// against an instruction-level cycle model, on MEM_LAT=1 and MEM_LAT=3 instances.
module tb_control_sequencer;

  typedef logic [26:0] vec_t;

  localparam vec_t M_PCOUT  = vec_t'(1) << 26;
  localparam vec_t M_MDROUT = vec_t'(1) << 25;
  localparam vec_t M_ZLOUT  = vec_t'(1) << 24;
  localparam vec_t M_COUT   = vec_t'(1) << 23;
  localparam vec_t M_GRA    = vec_t'(1) << 22;
  localparam vec_t M_GRB    = vec_t'(1) << 21;
  localparam vec_t M_GRC    = vec_t'(1) << 20;
  localparam vec_t M_RIN    = vec_t'(1) << 19;
  localparam vec_t M_ROUT   = vec_t'(1) << 18;
  localparam vec_t M_BAOUT  = vec_t'(1) << 17;
  localparam vec_t M_PCE    = vec_t'(1) << 16;
  localparam vec_t M_INCPC  = vec_t'(1) << 15;
  localparam vec_t M_MAR    = vec_t'(1) << 14;
  localparam vec_t M_MDRE   = vec_t'(1) << 13;
  localparam vec_t M_IRE    = vec_t'(1) << 12;
  localparam vec_t M_YE     = vec_t'(1) << 11;
  localparam vec_t M_ZLE    = vec_t'(1) << 10;
  localparam vec_t M_READ   = vec_t'(1) << 9;
  localparam vec_t M_WRITE  = vec_t'(1) << 8;
  localparam vec_t M_CONIN  = vec_t'(1) << 7;
  localparam vec_t M_DONE   = vec_t'(1) << 1;
  localparam vec_t M_HALTED = vec_t'(1);
  localparam vec_t BUS      = M_PCOUT | M_MDROUT | M_ZLOUT | M_COUT | M_ROUT | M_BAOUT;
  localparam vec_t FETCH0   = M_PCOUT | M_MAR | M_INCPC;
  localparam vec_t WB       = M_ZLOUT | M_GRA | M_RIN | M_DONE;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = 32'd0;
  logic        CON_output = 1'b0;
  wire  [26:0] o1;
  wire  [26:0] o3;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_LAT(1)) dut1 (
    .clock(clock), .clear(clear), .IR(IR), .CON_output(CON_output),
    .PCout(o1[26]), .MDRout(o1[25]), .ZLowout(o1[24]), .Cout(o1[23]),
    .GRA(o1[22]), .GRB(o1[21]), .GRC(o1[20]), .Rin(o1[19]), .Rout(o1[18]), .BAout(o1[17]),
    .PC_enable(o1[16]), .IncPC(o1[15]), .MAR_enable(o1[14]), .MDR_enable(o1[13]),
    .IR_enable(o1[12]), .Y_enable(o1[11]), .Z_low_enable(o1[10]),
    .Read(o1[9]), .Write(o1[8]), .CON_in(o1[7]), .operation(o1[6:2]),
    .instr_done(o1[1]), .halted(o1[0])
  );

  control_sequencer #(.MEM_LAT(3)) dut3 (
    .clock(clock), .clear(clear), .IR(IR), .CON_output(CON_output),
    .PCout(o3[26]), .MDRout(o3[25]), .ZLowout(o3[24]), .Cout(o3[23]),
    .GRA(o3[22]), .GRB(o3[21]), .GRC(o3[20]), .Rin(o3[19]), .Rout(o3[18]), .BAout(o3[17]),
    .PC_enable(o3[16]), .IncPC(o3[15]), .MAR_enable(o3[14]), .MDR_enable(o3[13]),
    .IR_enable(o3[12]), .Y_enable(o3[11]), .Z_low_enable(o3[10]),
    .Read(o3[9]), .Write(o3[8]), .CON_in(o3[7]), .operation(o3[6:2]),
    .instr_done(o3[1]), .halted(o3[0])
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t opv(input logic [4:0] x);
    return vec_t'(x) << 2;
  endfunction

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %07h expected %07h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One reset cycle with the instruction already on IR; next tick() lands in T0.
  task automatic start(input logic [31:0] ir, input logic con);
    @(negedge clock);
    IR = ir; CON_output = con; clear = 1'b0;
    tick();
    chk("reset1", o1, '0);
    chk("reset3", o3, '0);
    @(negedge clock);
    clear = 1'b1;
  endtask

  // Per-cycle output trace of one instruction, fetch included.
  vec_t mseq[$];

  task automatic build(input int lat, input logic [31:0] ir, input logic con);
    logic [4:0] op;
    logic [4:0] aluop;
    op = ir[31:27];
    mseq.delete();
    mseq.push_back(FETCH0);
    for (int i = 0; i < lat; i++) mseq.push_back(M_READ | ((i == lat - 1) ? M_MDRE : '0));
    mseq.push_back(M_MDROUT | M_IRE);
    if (op >= 5'd3 && op <= 5'd11) begin
      mseq.push_back(M_GRB | M_ROUT | M_YE);
      mseq.push_back(M_GRC | M_ROUT | opv(op) | M_ZLE);
      mseq.push_back(WB);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      aluop = (op == 5'd12) ? 5'b00011 : (op == 5'd13) ? 5'b00101 : 5'b00110;
      mseq.push_back(M_GRB | M_ROUT | M_YE);
      mseq.push_back(M_COUT | opv(aluop) | M_ZLE);
      mseq.push_back(WB);
    end else if (op <= 5'd2) begin
      mseq.push_back(M_GRB | M_BAOUT | M_YE);
      mseq.push_back(M_COUT | opv(5'b00011) | M_ZLE);
      if (op == 5'd1) begin
        mseq.push_back(WB);
      end else begin
        mseq.push_back(M_ZLOUT | M_MAR);
        if (op == 5'd0) begin
          for (int i = 0; i < lat; i++) mseq.push_back(M_READ | ((i == lat - 1) ? M_MDRE : '0));
          mseq.push_back(M_MDROUT | M_GRA | M_RIN | M_DONE);
        end else begin
          mseq.push_back(M_GRA | M_ROUT | M_MDRE);
          mseq.push_back(M_WRITE | M_DONE);
        end
      end
    end else if (op == 5'd18) begin
      mseq.push_back(M_GRA | M_ROUT | M_CONIN);
      mseq.push_back(M_PCOUT | M_YE);
      mseq.push_back(M_COUT | opv(5'b00011) | M_ZLE);
      mseq.push_back(M_DONE | (con ? (M_ZLOUT | M_PCE) : '0));
    end else if (op == 5'd19) begin
      mseq.push_back(M_GRA | M_ROUT | M_PCE | M_DONE);
    end else begin
      mseq.push_back(M_DONE);
    end
  endtask

  task automatic run_model(input logic [31:0] ir, input logic con, input int ncyc);
    vec_t s1[$];
    vec_t s3[$];
    vec_t e1;
    vec_t e3;
    bit   halts;
    halts = (ir[31:27] == 5'd27);
    build(1, ir, con); s1 = mseq;
    build(3, ir, con); s3 = mseq;
    start(ir, con);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      e1 = (c < s1.size()) ? s1[c] : (halts ? M_HALTED : s1[c % s1.size()]);
      e3 = (c < s3.size()) ? s3[c] : (halts ? M_HALTED : s3[c % s3.size()]);
      chk($sformatf("model1 ir=%08h c=%0d", ir, c), o1, e1);
      chk($sformatf("model3 ir=%08h c=%0d", ir, c), o3, e3);
      chk_int($sformatf("bus1 c=%0d", c), int'($countones(o1 & BUS) <= 1), 1);
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    logic        con;
    int          cyc;
    vec_t        exp;
  } vec_rec_t;

  vec_rec_t tbl[$];

  task automatic add_vec(input logic [31:0] ir, input logic con, input int cyc, input vec_t exp);
    vec_rec_t r;
    r.ir = ir; r.con = con; r.cyc = cyc; r.exp = exp;
    tbl.push_back(r);
  endtask

  initial begin
    int   reads;
    int   writes;
    int   mdre;
    int   done_at;
    vec_t last;

    // Expected outputs of the MEM_LAT=1 instance at cycle cyc (0 = T0).
    add_vec(32'h18918000, 1'b0, 0, FETCH0);
    add_vec(32'h18918000, 1'b0, 1, M_READ | M_MDRE);
    add_vec(32'h18918000, 1'b0, 2, M_MDROUT | M_IRE);
    add_vec(32'h18918000, 1'b0, 3, M_GRB | M_ROUT | M_YE);
    add_vec(32'h18918000, 1'b0, 4, M_GRC | M_ROUT | opv(5'b00011) | M_ZLE);
    add_vec(32'h18918000, 1'b0, 5, WB);
    add_vec(32'h18918000, 1'b0, 6, FETCH0);
    add_vec(32'h20000000, 1'b0, 4, M_GRC | M_ROUT | opv(5'b00100) | M_ZLE);
    add_vec(32'h58000000, 1'b0, 4, M_GRC | M_ROUT | opv(5'b01011) | M_ZLE);
    add_vec(32'h68000000, 1'b0, 4, M_COUT | opv(5'b00101) | M_ZLE);
    add_vec(32'h70000000, 1'b0, 4, M_COUT | opv(5'b00110) | M_ZLE);
    add_vec(32'h08000000, 1'b0, 5, WB);
    add_vec(32'h10900010, 1'b0, 6, M_GRA | M_ROUT | M_MDRE);
    add_vec(32'h10900010, 1'b0, 7, M_WRITE | M_DONE);
    add_vec(32'h90000000, 1'b1, 3, M_GRA | M_ROUT | M_CONIN);
    add_vec(32'h90000000, 1'b1, 6, M_DONE | M_ZLOUT | M_PCE);
    add_vec(32'h90000000, 1'b0, 6, M_DONE);
    add_vec(32'h98000000, 1'b0, 3, M_GRA | M_ROUT | M_PCE | M_DONE);
    add_vec(32'h98000000, 1'b0, 4, FETCH0);
    add_vec(32'hD0000000, 1'b0, 3, M_DONE);
    add_vec(32'hF8000000, 1'b0, 4, FETCH0);
    add_vec(32'hD8000000, 1'b0, 3, M_DONE);
    add_vec(32'hD8000000, 1'b0, 4, M_HALTED);

    foreach (tbl[i]) begin
      start(tbl[i].ir, tbl[i].con);
      for (int k = 0; k <= tbl[i].cyc; k++) tick();
      chk($sformatf("tbl%0d", i), o1, tbl[i].exp);
    end

    // ld with three-cycle memory: 12 cycles, two read waits.
    start(32'h00900010, 1'b0);
    reads = 0; mdre = 0; done_at = -1; last = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o3[9]) reads++;
      if (o3[13]) mdre |= (1 << c);
      if (o3[1] && done_at < 0) done_at = c;
      if (c == 11) last = o3;
    end
    tick();
    chk_int("ld_reads", reads, 6);
    chk_int("ld_mdre_cycles", mdre, (1 << 3) | (1 << 10));
    chk_int("ld_done_cycle", done_at, 11);
    chk("ld_t7", last, M_MDROUT | M_GRA | M_RIN | M_DONE);
    chk("ld_refetch", o3, FETCH0);

    // st with three-cycle memory: one Write, T6 loads MDR without Read.
    start(32'h10900010, 1'b0);
    writes = 0; last = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o3[8]) writes++;
      if (c == 8) last = o3;
    end
    chk_int("st_writes", writes, 1);
    chk("st_t6", last, M_GRA | M_ROUT | M_MDRE);

    // halt holds until clear pulses low.
    start(32'hD8000000, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    chk("halt_t3", o1, M_DONE);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("halt_hold%0d", c), o1, M_HALTED);
    end
    @(negedge clock); clear = 1'b0;
    tick();
    chk("halt_clear", o1, '0);
    @(negedge clock); clear = 1'b1;
    tick();
    chk("halt_restart", o1, FETCH0);

    // clear in the middle of ld T4.
    start(32'h00900010, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    chk("ld_t4", o1, M_COUT | opv(5'b00011) | M_ZLE);
    @(negedge clock); clear = 1'b0;
    tick();
    chk("mid_clear1", o1, '0);
    chk("mid_clear3", o3, '0);
    @(negedge clock); clear = 1'b1;
    tick();
    chk("mid_restart", o1, FETCH0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ir;
      ir = {5'($urandom_range(0, 31)), 27'($urandom)};
      run_model(ir, 1'($urandom_range(0, 1)), 26);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control unit for the single-bus 32-bit CPU datapath. It decodes the IR opcode and steps a T-state machine through fetch and execute. In each state it drives the datapath's register-enable, bus-select, ALU-operation and memory strobes. It owns instruction sequencing, memory-wait handling, conditional-branch resolution and halt.

Parameters:
MEM_LAT, 1, cycles Read is held before MDR capture (1..7)
ADD_OP, 5'b00011, ALU operation code used for address/immediate/branch-offset adds
AND_OP, 5'b00101, ALU operation code for andi
OR_OP, 5'b00110, ALU operation code for ori

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous, active-low reset
IR  in  32  instruction register contents; opcode IR[31:27]
CON_output  in  1  branch condition from CON FF
PCout,MDRout,ZLowout,Cout  out  1 each  bus-source selects
GRA,GRB,GRC,Rin,Rout,BAout  out  1 each  IR register-field selects
PC_enable,IncPC,MAR_enable,MDR_enable,IR_enable,Y_enable,Z_low_enable  out  1 each  register loads
Read  out  1  MDR source = memory
Write  out  1  RAM write enable (datapath RAM_enable)
CON_in  out  1  CON FF load
operation  out  5  ALU operation
instr_done  out  1  one-cycle pulse in final step of each instruction
halted  out  1  high while in HALT

Behaviour:
- Outputs are Moore: combinational decode of the registered state, step counter and opcode.
- While clear=0: state=RST and all outputs are 0. This also applies mid-instruction.
- The first rising edge with clear=1 enters T0.
- operation defaults to 0 when not listed below.
- Fetch sequence:
  - T0: PCout, MAR_enable, IncPC.
  - T1: Read=1 for MEM_LAT cycles (wait counter); MDR_enable only in the last of these cycles.
  - T2: MDRout, IR_enable.
- R-format, opcodes 00011–01011:
  - T3: GRB, Rout, Y_enable.
  - T4: GRC, Rout, operation=IR[31:27], Z_low_enable.
  - T5: ZLowout, GRA, Rin, instr_done.
- Immediate, opcodes 01100 addi / 01101 andi / 01110 ori:
  - T3 as R-format.
  - T4: Cout, operation=ADD_OP/AND_OP/OR_OP respectively, Z_low_enable.
  - T5 as R-format.
- ld 00000 / ldi 00001 / st 00010:
  - T3: GRB, BAout, Y_enable.
  - T4: Cout, operation=ADD_OP, Z_low_enable.
  - ldi T5: ZLowout, GRA, Rin, instr_done.
  - ld and st T5: ZLowout, MAR_enable.
  - ld T6: Read for MEM_LAT cycles, MDR_enable in the last of these cycles.
  - ld T7: MDRout, GRA, Rin, instr_done.
  - st T6: GRA, Rout, MDR_enable, Read=0.
  - st T7: Write=1 for exactly 1 cycle, instr_done.
- br 10010:
  - T3: GRA, Rout, CON_in.
  - T4: PCout, Y_enable.
  - T5: Cout, operation=ADD_OP, Z_low_enable.
  - T6: instr_done; ZLowout and PC_enable are asserted only if CON_output=1.
- jr 10011:
  - T3: GRA, Rout, PC_enable, instr_done.
- nop 11010 and any undefined opcode:
  - T3: instr_done only.
- halt 11011:
  - T3: instr_done, then HALT.
  - HALT: halted=1, all other outputs 0; exit only via clear=0.
- Step after instr_done: T0 next cycle (no dead cycles).
- Opcode is sampled from IR in T3 onward; IR must not change outside T2.
- Wait counter resets on every T1/T6 entry; MEM_LAT=1 gives single-cycle T1/T6.
- At most one bus-source signal (PCout, MDRout, ZLowout, Cout, Rout, BAout) is high in any cycle.

Optional Feature:
STEP_EN:
- Adds input step (1 bit).
- With the macro defined: after instr_done, the FSM enters IDLE (all outputs 0) and advances to T0 on the cycle after step=1 is sampled. step held high runs continuously. HALT still takes priority.
- Without the macro: there is no step port and no IDLE state; fetch follows instr_done directly.

Test Plan:
1. Reset then IR=0x18918000 (add R1,R2,R3), MEM_LAT=1.
   Required: T0..T5 = 6 cycles; T4 operation=00011 with GRC, Rout; instr_done in cycle 6; T0 in cycle 7.
2. ld with IR=0x00900010, MEM_LAT=3.
   Required: Read high 3 cycles in T1 and in T6, MDR_enable only in the 3rd; total 12 cycles; T7 asserts MDRout, GRA, Rin.
3. st with IR=0x10900010.
   Required: Write high exactly 1 cycle in T7; Read=0 in T6; MDR_enable in T6.
4. br with CON_output=1, then with CON_output=0.
   Required: taken asserts ZLowout and PC_enable in T6; not-taken asserts neither; both pulse instr_done.
5. IR=0xD8000000 (halt).
   Required: halted=1 from the cycle after T3, all other outputs 0 for 20 cycles; clear=0 for 1 cycle then clear=1 gives T0 with halted=0.
6. clear=0 asserted during ld T4.
   Required: all outputs 0 on the next edge; after release, restart at T0 with PCout, MAR_enable, IncPC.
